// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : RISC-V MEM stage, byte-serial little-endian load/store engine
// Revision  : 1.0
// ============================================================================
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REGA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REGA_W-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ld,
  input  logic              mem_st,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_sdata,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_we,
  output logic              stall_req,
  output logic [REGA_W-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [DATA_W-1:0] wb_wdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        r_state;
  logic [2:0]        r_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sdata;
  logic [2:0]        r_f3;
  logic [REGA_W-1:0] r_wd;
  logic              r_wreg;
  logic              r_ld;
  logic [DATA_W-1:0] r_ldata;
  logic [REGA_W-1:0] r_wb_wd;
  logic              r_wb_wreg;
  logic [DATA_W-1:0] r_wb_wdata;

  logic [2:0]        w_nbytes;
  logic              w_issue;
  logic              w_last;
  logic [ADDR_W-1:0] w_idx_ext;
  logic [4:0]        w_st_sel;
  logic [1:0]        w_cap_idx;
  logic [4:0]        w_cap_sel;
  logic [DATA_W-1:0] w_ldres;

  always_comb begin
    unique case (r_f3[1:0])
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // Loads spend one extra cycle collecting the byte read on the final address.
  assign w_issue   = (r_idx < w_nbytes);
  assign w_last    = r_ld ? (r_idx == w_nbytes) : (r_idx == (w_nbytes - 3'd1));
  assign w_idx_ext = {{(ADDR_W-3){1'b0}}, r_idx};
  assign w_st_sel  = {r_idx[1:0], 3'b000};
  assign w_cap_idx = r_idx[1:0] - 2'd1;
  assign w_cap_sel = {w_cap_idx, 3'b000};

  always_comb begin
    ram_addr = '0;
    ram_dout = 8'h00;
    ram_we   = 1'b0;
    if (r_state == S_ACCESS && w_issue) begin
      ram_addr = r_addr + w_idx_ext;
      if (!r_ld) begin
        ram_we   = 1'b1;
        ram_dout = r_sdata[w_st_sel +: 8];
      end
    end
  end

  // Gated by reset so a held ld/st in ex_mem cannot assert stall while in reset.
  assign stall_req = rst & (((r_state == S_IDLE) & (mem_ld | mem_st)) | (r_state == S_ACCESS));

  always_comb begin
    unique case (r_f3)
      3'b000:  w_ldres = {{(DATA_W-8){r_ldata[7]}}, r_ldata[7:0]};
      3'b100:  w_ldres = {{(DATA_W-8){1'b0}}, r_ldata[7:0]};
      3'b001:  w_ldres = {{(DATA_W-16){r_ldata[15]}}, r_ldata[15:0]};
      3'b101:  w_ldres = {{(DATA_W-16){1'b0}}, r_ldata[15:0]};
      default: w_ldres = r_ldata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_addr     <= '0;
      r_sdata    <= '0;
      r_f3       <= 3'd0;
      r_wd       <= '0;
      r_wreg     <= 1'b0;
      r_ld       <= 1'b0;
      r_ldata    <= '0;
      r_wb_wd    <= '0;
      r_wb_wreg  <= 1'b0;
      r_wb_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (mem_ld | mem_st) begin
            r_addr    <= mem_addr;
            r_sdata   <= mem_sdata;
            r_f3      <= mem_funct3;
            r_wd      <= mem_wd;
            r_wreg    <= mem_wreg;
            r_ld      <= mem_ld;
            r_ldata   <= '0;
            r_idx     <= 3'd0;
            r_wb_wreg <= 1'b0;
            r_state   <= S_ACCESS;
          end else begin
            r_wb_wd    <= mem_wd;
            r_wb_wreg  <= mem_wreg;
            r_wb_wdata <= mem_wdata;
          end
        end
        S_ACCESS: begin
          r_wb_wreg <= 1'b0;
          if (r_ld && r_idx != 3'd0) begin
            r_ldata[w_cap_sel +: 8] <= ram_din;
          end
          r_idx <= r_idx + 3'd1;
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_wb_wd    <= r_wd;
          r_wb_wreg  <= r_ld & r_wreg;
          r_wb_wdata <= r_ld ? w_ldres : '0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb_wd    = r_wb_wd;
  assign wb_wreg  = r_wb_wreg;
  assign wb_wdata = r_wb_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : directed + random checks of mem_stage against a byte-map model
// Revision     : 1.0
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_ld;
  logic        mem_st;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic [7:0]  ram_din;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic        stall_req;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32), .DATA_W(32), .REGA_W(5)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .mem_wd     (mem_wd),
    .mem_wreg   (mem_wreg),
    .mem_wdata  (mem_wdata),
    .mem_ld     (mem_ld),
    .mem_st     (mem_st),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_sdata  (mem_sdata),
    .ram_din    (ram_din),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .ram_we     (ram_we),
    .stall_req  (stall_req),
    .wb_wd      (wb_wd),
    .wb_wreg    (wb_wreg),
    .wb_wdata   (wb_wdata)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] ram   [logic [31:0]];
  logic [7:0] model [logic [31:0]];
  wr_t        wr_q  [$];

  // Byte RAM with registered read: data for an address appears the next cycle.
  always @(posedge clk) begin
    ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
    if (ram_we) begin
      ram[ram_addr] = ram_dout;
      wr_q.push_back('{ram_addr, ram_dout});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mrd(input logic [31:0] a);
    return model.exists(a) ? model[a] : 8'h00;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]   = d;
    model[a] = d;
  endtask

  // Issues one instruction at a negedge, holds it through the stall, and
  // checks writeback, stall length, bubbles and RAM write traffic.
  task automatic run(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] sdata,
                     input logic [4:0] wd, input logic wr, input logic [31:0] wdata,
                     input string tag);
    int          n;
    int          exp_stall;
    int          cnt;
    logic [31:0] v;
    logic        exp_wreg;
    wr_t         exp_w [$];
    n = nbytes(f3);
    if (ld) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mrd(addr + 32'(i))) << (8 * i));
      if (f3 == 3'b000 && v[7])  v = v - 32'h100;
      if (f3 == 3'b001 && v[15]) v = v - 32'h10000;
      exp_wreg  = wr;
      exp_stall = 2 + n;
    end else if (st) begin
      for (int i = 0; i < n; i++) begin
        exp_w.push_back('{addr + 32'(i), sdata[8*i +: 8]});
        model[addr + 32'(i)] = sdata[8*i +: 8];
      end
      v         = 32'h0;
      exp_wreg  = 1'b0;
      exp_stall = 1 + n;
    end else begin
      v         = wdata;
      exp_wreg  = wr;
      exp_stall = 0;
    end
    wr_q.delete();
    mem_ld = ld; mem_st = st; mem_funct3 = f3; mem_addr = addr;
    mem_sdata = sdata; mem_wd = wd; mem_wreg = wr; mem_wdata = wdata;
    #1;
    cnt = 0;
    while (stall_req === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk); #1;
      check({tag, ".bubble"}, 32'(wb_wreg), 32'h0);
    end
    check({tag, ".stall"}, 32'(cnt), 32'(exp_stall));
    @(negedge clk); #1;
    mem_ld = 1'b0; mem_st = 1'b0;
    check({tag, ".wb_wd"},    32'(wb_wd),   32'(wd));
    check({tag, ".wb_wreg"},  32'(wb_wreg), 32'(exp_wreg));
    check({tag, ".wb_wdata"}, wb_wdata,     v);
    check({tag, ".nwrites"},  32'(wr_q.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++) begin
      check({tag, ".wr_addr"}, wr_q[i].a,      exp_w[i].a);
      check({tag, ".wr_data"}, 32'(wr_q[i].d), 32'(exp_w[i].d));
    end
  endtask

  initial begin
    rst = 1'b0;
    mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_ld = 1'b1; mem_st = 1'b0;
    mem_funct3 = '0; mem_addr = '0; mem_sdata = '0;
    @(negedge clk); @(negedge clk); #1;
    check("rst.stall", 32'(stall_req), 32'h0);
    check("rst.we",    32'(ram_we),    32'h0);
    check("rst.addr",  ram_addr,       32'h0);
    check("rst.wb",    {wb_wdata[25:0], wb_wd, wb_wreg}, 32'h0);
    mem_ld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    preload(32'h20, 8'h80);
    preload(32'h21, 8'h01);
    preload(32'hFFFF_FFFE, 8'h11);
    preload(32'hFFFF_FFFF, 8'h22);
    preload(32'h0000_0000, 8'h33);
    preload(32'h0000_0001, 8'h44);

    run(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, "alu");
    run(1'b0, 1'b1, 3'b010, 32'h100, 32'hAABB_CCDD, 5'd9, 1'b1, 32'h0, "sw");
    run(1'b1, 1'b0, 3'b000, 32'h20, 32'h0, 5'd7, 1'b1, 32'h0, "lb");
    check("lb.const", wb_wdata, 32'hFFFF_FF80);
    run(1'b1, 1'b0, 3'b100, 32'h20, 32'h0, 5'd8, 1'b1, 32'h0, "lbu");
    check("lbu.const", wb_wdata, 32'h0000_0080);
    run(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 5'd10, 1'b1, 32'h0, "lw_wrap");
    check("lw_wrap.const", wb_wdata, 32'h4433_2211);
    run(1'b1, 1'b0, 3'b001, 32'h20, 32'h0, 5'd11, 1'b1, 32'h0, "lh");
    run(1'b0, 1'b1, 3'b000, 32'h40, 32'h0000_005A, 5'd12, 1'b1, 32'h0, "sb");
    run(1'b1, 1'b1, 3'b101, 32'h20, 32'hDEAD_BEEF, 5'd13, 1'b1, 32'h0, "ldst");

    // Reset while a store is between its second and third byte.
    wr_q.delete();
    mem_st = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h200; mem_sdata = 32'h0102_0304;
    mem_wd = 5'd3; mem_wreg = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid.we",    32'(ram_we),    32'h0);
    check("rstmid.stall", 32'(stall_req), 32'h0);
    check("rstmid.addr",  ram_addr,       32'h0);
    check("rstmid.wb",    {wb_wdata[25:0], wb_wd, wb_wreg}, 32'h0);
    check("rstmid.wbd",   wb_wdata,       32'h0);
    check("rstmid.nwr",   32'(wr_q.size()), 32'd2);
    model[32'h200] = 8'h04;
    model[32'h201] = 8'h03;
    mem_st = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd21, 1'b1, 32'hCAFE_F00D, "post_rst");
    run(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd22, 1'b1, 32'h0, "post_rst_lw");

    for (int k = 0; k < 60; k++) begin
      int          typ;
      logic        rld;
      logic        rst_q;
      logic [31:0] a;
      typ   = int'($urandom_range(0, 2));
      a     = ($urandom_range(0, 1) == 0) ? (32'h300 + 32'($urandom_range(0, 15)))
                                          : (32'hFFFF_FFFC + 32'($urandom_range(0, 3)));
      rld   = (typ == 1) || (typ == 2 && $urandom_range(0, 5) == 0);
      rst_q = (typ == 2);
      run(rld, rst_q, 3'($urandom_range(0, 7)), a, $urandom, 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
